// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the multicycle controller and the RV32M
// multiply/divide unit; clock and reset stay outside as plain ports.
interface mul_div_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start_i;
    logic [2:0]            funct3_i;
    logic [DATA_WIDTH-1:0] srcA_i;
    logic [DATA_WIDTH-1:0] srcB_i;
    logic                  busy_o;
    logic                  done_o;
    logic [DATA_WIDTH-1:0] result_o;

    modport master (
        output start_i, funct3_i, srcA_i, srcB_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, funct3_i, srcA_i, srcB_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply or restoring divide on
// operand magnitudes, sign fix-up at the end, fixed 33-cycle start-to-done.
module mul_div_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 5
) (
    input  logic           clk_i,
    input  logic           reset_i,
    mul_div_unit_if.slave  bus
);
    localparam int W  = DATA_WIDTH;
    localparam int W2 = 2 * DATA_WIDTH;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [W-1:0] INT_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_accept;

    logic [2:0]             r_op;
    logic                   r_a_neg;
    logic                   r_b_neg;
    logic [W-1:0]           r_mag_a;
    logic [W-1:0]           r_mag_b;
    logic [W2-1:0]          r_acc;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_done;
    logic [W-1:0]           r_result;

    logic                   w_a_signed;
    logic                   w_b_signed;
    logic                   w_in_a_neg;
    logic                   w_in_b_neg;
    logic [W-1:0]           w_in_mag_a;
    logic [W-1:0]           w_in_mag_b;

    logic [W:0]             w_mul_sum;
    logic [W2-1:0]          w_mul_nxt;
    logic [W:0]             w_div_rem;
    logic                   w_div_ge;
    logic [W-1:0]           w_div_sub;
    logic [W2-1:0]          w_div_nxt;

    logic [W2-1:0]          w_prod;
    logic [W-1:0]           w_quo;
    logic [W-1:0]           w_rem;
    logic [W-1:0]           w_orig_a;
    logic                   w_div0;
    logic                   w_ovf;
    logic [W-1:0]           w_fix_result;

    // Operand sign capture: only MULH/MULHSU/DIV/REM treat operands as signed.
    always_comb begin
        w_a_signed = (bus.funct3_i == OP_MULH) || (bus.funct3_i == OP_MULHSU) ||
                     (bus.funct3_i == OP_DIV)  || (bus.funct3_i == OP_REM);
        w_b_signed = (bus.funct3_i == OP_MULH) ||
                     (bus.funct3_i == OP_DIV)  || (bus.funct3_i == OP_REM);
        w_in_a_neg = w_a_signed && bus.srcA_i[W-1];
        w_in_b_neg = w_b_signed && bus.srcB_i[W-1];
        w_in_mag_a = w_in_a_neg ? -bus.srcA_i : bus.srcA_i;
        w_in_mag_b = w_in_b_neg ? -bus.srcB_i : bus.srcB_i;
    end

    // Multiply keeps the multiplier in the low half and shifts it out as the
    // product grows in from the top; divide keeps {rem, quo} with a 33-bit
    // working remainder so the shifted-out carry is never lost.
    always_comb begin
        w_mul_sum = {1'b0, r_acc[W2-1:W]} + (r_acc[0] ? {1'b0, r_mag_a} : {(W+1){1'b0}});
        w_mul_nxt = {w_mul_sum, r_acc[W-1:1]};
        w_div_rem = r_acc[W2-1:W-1];
        w_div_ge  = (w_div_rem >= {1'b0, r_mag_b});
        w_div_sub = w_div_rem[W-1:0] - r_mag_b;
        w_div_nxt = w_div_ge ? {w_div_sub, r_acc[W-2:0], 1'b1}
                             : {w_div_rem[W-1:0], r_acc[W-2:0], 1'b0};
    end

    always_comb begin
        w_prod   = (r_a_neg ^ r_b_neg) ? -r_acc : r_acc;
        w_quo    = (r_a_neg ^ r_b_neg) ? -r_acc[W-1:0] : r_acc[W-1:0];
        w_rem    = r_a_neg ? -r_acc[W2-1:W] : r_acc[W2-1:W];
        w_orig_a = r_a_neg ? -r_mag_a : r_mag_a;
        w_div0   = (r_mag_b == {W{1'b0}});
        w_ovf    = r_a_neg && r_b_neg && (r_mag_a == INT_MIN) && (r_mag_b == {{(W-1){1'b0}}, 1'b1});
        unique case (r_op)
            OP_MUL:                       w_fix_result = w_prod[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_result = w_prod[W2-1:W];
            OP_DIV, OP_DIVU:              w_fix_result = w_div0 ? {W{1'b1}} : (w_ovf ? INT_MIN : w_quo);
            OP_REM, OP_REMU:              w_fix_result = w_div0 ? w_orig_a : (w_ovf ? {W{1'b0}} : w_rem);
            default:                      w_fix_result = {W{1'b0}};
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (r_count == COUNT_WIDTH'(W - 1)) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_count  <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= (r_state == S_FIX);
            if (r_state == S_FIX) begin
                r_result <= w_fix_result;
            end
            if (w_accept) begin
                r_count <= '0;
            end else if (r_state == S_CALC) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_op    <= bus.funct3_i;
            r_a_neg <= w_in_a_neg;
            r_b_neg <= w_in_b_neg;
            r_mag_a <= w_in_mag_a;
            r_mag_b <= w_in_mag_b;
            r_acc   <= {{W{1'b0}}, (bus.funct3_i[2] ? w_in_mag_a : w_in_mag_b)};
        end else if (r_state == S_CALC) begin
            r_acc <= r_op[2] ? w_div_nxt : w_mul_nxt;
        end
    end

    assign bus.busy_o   = (r_state != S_IDLE);
    assign bus.done_o   = r_done;
    assign bus.result_o = r_result;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: expected results and completion
// cycles are queued at issue time and checked when done_o pulses.
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_div_unit_if u_if ();

    mul_div_unit u_dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (u_if)
    );

    typedef struct {
        logic [31:0] res;
        int          at;
        string       nm;
    } exp_t;

    exp_t sb[$];

    localparam int NV = 16;
    logic [2:0]  v_f3 [NV] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b101, 3'b111,
                               3'b101, 3'b111, 3'b100, 3'b110, 3'b110, 3'b001, 3'b100, 3'b110};
    logic [31:0] v_a   [NV] = '{32'h7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                               32'd5, 32'd5, 32'h80000000, 32'h80000000,
                               32'hFFFFFFFB, 32'hFFFFFFFF, 32'd14, 32'd14};
    logic [31:0] v_b   [NV] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'd2, 32'd2, 32'd7, 32'd7,
                               32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'd0, 32'd3, 32'hFFFFFFFD, 32'hFFFFFFFD};
    logic [31:0] v_exp [NV] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                               32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                               32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0,
                               32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'd2};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Call from a point away from the clock edge; the start is taken on the next posedge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] req, input bit track, input string nm);
        u_if.start_i  = 1'b1;
        u_if.funct3_i = f3;
        u_if.srcA_i   = a;
        u_if.srcB_i   = b;
        @(posedge clk);
        #1;
        check({nm, "_busy"}, {31'b0, u_if.busy_o}, 32'd1);
        if (track) sb.push_back('{req, cyc + 33, nm});
        u_if.start_i  = 1'b0;
        u_if.funct3_i = ~f3;
        u_if.srcA_i   = ~a;
        u_if.srcB_i   = $urandom;
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (u_if.busy_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("idle_wait", {31'b0, u_if.busy_o}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (u_if.done_o) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_miss++;
                $display("FAIL spurious_done: result %h at cycle %0d, nothing outstanding", u_if.result_o, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.nm, "_result"}, u_if.result_o, e.res);
                check({e.nm, "_latency"}, cyc, e.at);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        u_if.start_i  = 1'b0;
        u_if.funct3_i = 3'b000;
        u_if.srcA_i   = '0;
        u_if.srcB_i   = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy",   {31'b0, u_if.busy_o}, 32'd0);
        check("reset_done",   {31'b0, u_if.done_o}, 32'd0);
        check("reset_result", u_if.result_o, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            wait_idle();
            issue(v_f3[i], v_a[i], v_b[i], v_exp[i], 1'b1, $sformatf("vec%0d", i));
        end

        // Start ignored while busy; operand inputs churn mid-operation.
        wait_idle();
        issue(3'b100, 32'd100, 32'd7, 32'd14, 1'b1, "div_midop");
        repeat (9) @(posedge clk);
        @(negedge clk);
        u_if.start_i  = 1'b1;
        u_if.funct3_i = 3'b011;
        u_if.srcA_i   = 32'hFFFFFFFF;
        u_if.srcB_i   = 32'd2;
        @(posedge clk);
        #1;
        u_if.start_i = 1'b0;
        u_if.srcA_i  = 32'h12345678;
        k = 0;
        @(negedge clk);
        while (!u_if.done_o && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("midop_done_seen", {31'b0, u_if.done_o}, 32'd1);
        issue(3'b011, 32'hFFFFFFFF, 32'd2, 32'd1, 1'b1, "b2b_mulhu");

        // Reset abort in the middle of a multiply.
        wait_idle();
        issue(3'b000, 32'd3, 32'd5, 32'd15, 1'b0, "mul_aborted");
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy",   {31'b0, u_if.busy_o}, 32'd0);
        check("abort_done",   {31'b0, u_if.done_o}, 32'd0);
        check("abort_result", u_if.result_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        rst = 1'b1;
        u_if.start_i  = 1'b1;
        u_if.funct3_i = 3'b000;
        @(posedge clk);
        #1;
        check("reset_beats_start", {31'b0, u_if.busy_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        u_if.start_i = 1'b0;

        wait_idle();
        issue(3'b000, 32'd3, 32'd5, 32'd15, 1'b1, "mul_after_abort");
        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end
endmodule
